// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
// Holds the scheduler state encoding and the default byte and word geometry
// used by uart_tx_scheduler.
package uart_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } tx_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid[1:0]  - request lines
//   last_grant  - index of the requester served most recently
//   grant[1:0]  - one-hot winner, or zero when nobody requests
// When both request, the requester that was not served last wins.
// Also intended for reuse by the RX-side command router.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_grant)) begin
      grant[0] = 1'b1;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between two word-level requesters.
// A granted word is latched and sent byte by byte, LSB first; each byte is
// launched with a one-cycle start strobe and the next one waits for the
// transmitter's done pulse. A word whose byte is not acknowledged within
// TIMEOUT cycles is dropped.
// Ports:
//   clk, uart_reset (async, active-low)
//   req0_valid/req0_data/req0_ready, req1_valid/req1_data/req1_ready
//                          - word handshakes, ready only while idle
//   dataToSend             - registered byte for the transmitter
//   uart_tx_start          - one-cycle start strobe
//   uart_tx_done           - transmitter's end-of-byte pulse
//   busy, grant_id         - in-flight status and word owner
//   word_done, timeout_err - one-cycle completion / abort pulses
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int NBYTES  = NBYTES_DEF,
  parameter int TIMEOUT = 2000000
) (
  input  logic                   clk,
  input  logic                   uart_reset,
  input  logic                   req0_valid,
  input  logic [DBIT*NBYTES-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [DBIT*NBYTES-1:0] req1_data,
  output logic                   req1_ready,
  output logic [DBIT-1:0]        dataToSend,
  output logic                   uart_tx_start,
  input  logic                   uart_tx_done,
  output logic                   busy,
  output logic                   grant_id,
  output logic                   word_done,
  output logic                   timeout_err
);

  localparam int WORD_W = DBIT * NBYTES;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(TIMEOUT);

  tx_state_t         state, state_nxt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] shift_nxt;
  logic [WORD_W-1:0] word_in;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TMR_W-1:0]  timer;
  logic              last_grant;
  logic [1:0]        grant;
  logic              in_idle;
  logic              accept;
  logic              winner;
  logic              next_byte;

  rr_arbiter_2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is combinational and masked by reset so it drops immediately
  // when reset is asserted, not at the next edge.
  assign in_idle    = (state == IDLE);
  assign req0_ready = in_idle & uart_reset & grant[0];
  assign req1_ready = in_idle & uart_reset & grant[1];
  assign accept     = req0_ready | req1_ready;
  assign winner     = grant[1];
  assign word_in    = winner ? req1_data : req0_data;
  assign shift_nxt  = shift_reg >> DBIT;
  assign busy       = !in_idle;
  assign next_byte  = (state == WAIT_DONE) && uart_tx_done && (byte_cnt != LAST_BYTE);

  always_ff @(posedge clk or negedge uart_reset) begin
    if (!uart_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    uart_tx_start = 1'b0;
    word_done     = 1'b0;
    timeout_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        uart_tx_start = 1'b1;
        state_nxt     = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving in the expiry cycle still completes the byte.
        if (uart_tx_done) begin
          state_nxt = (byte_cnt == LAST_BYTE) ? FINISH : START;
        end else if (timer == TMR_LIMIT) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      FINISH: begin
        word_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dataToSend is loaded on the way into START so the byte is already
  // stable while the strobe is high, and it holds until the next START.
  always_ff @(posedge clk or negedge uart_reset) begin
    if (!uart_reset) begin
      shift_reg  <= '0;
      dataToSend <= '0;
      byte_cnt   <= '0;
      timer      <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg  <= word_in;
            dataToSend <= word_in[DBIT-1:0];
            byte_cnt   <= '0;
            grant_id   <= winner;
            last_grant <= winner;
          end
        end
        START: begin
          timer <= '0;
        end
        WAIT_DONE: begin
          if (timer != TMR_SAT) timer <= timer + 1'b1;
          if (next_byte) begin
            shift_reg  <= shift_nxt;
            dataToSend <= shift_nxt[DBIT-1:0];
            byte_cnt   <= byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (DBIT=8, NBYTES=4, TIMEOUT=50).
// A transmitter model answers each start with a done pulse 10 cycles later.
module tb_uart_tx_scheduler;

  localparam int DBIT    = 8;
  localparam int NBYTES  = 4;
  localparam int TIMEOUT = 50;

  logic        clk        = 1'b0;
  logic        uart_reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data  = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data  = '0;
  logic        req1_ready;
  logic [7:0]  dataToSend;
  logic        uart_tx_start;
  logic        uart_tx_done;
  logic        busy;
  logic        grant_id;
  logic        word_done;
  logic        timeout_err;

  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  assign uart_tx_done = model_done | spur_done;

  uart_tx_scheduler #(.DBIT(DBIT), .NBYTES(NBYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .uart_reset    (uart_reset),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .dataToSend    (dataToSend),
    .uart_tx_start (uart_tx_start),
    .uart_tx_done  (uart_tx_done),
    .busy          (busy),
    .grant_id      (grant_id),
    .word_done     (word_done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int overlap  = 0;
  int acc_at   = 0;
  int model_cnt = 0;
  logic acc0_p = 1'b0;
  logic acc1_p = 1'b0;
  bit tx_en = 1'b1;
  bit spur_start_en = 1'b0;
  bit spur_idle_pulse = 1'b0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          start_cyc[$];
  logic [7:0]  bytes[$];
  logic        gid_log[$];
  int          done_cyc[$];
  int          wd_cyc[$];
  int          to_cyc[$];
  int          acc_id[$];
  int          acc_cyc[$];

  // Edge-side bookkeeping: cycle count, acceptances, start-over-done overlap.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    acc0_p <= req0_valid & req0_ready;
    acc1_p <= req1_valid & req1_ready;
    acc_at <= cyc;
    if (uart_tx_start && model_done) overlap <= overlap + 1;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (uart_tx_start) begin
      start_cyc.push_back(cyc);
      bytes.push_back(dataToSend);
      gid_log.push_back(grant_id);
    end
    if (word_done)   wd_cyc.push_back(cyc);
    if (timeout_err) to_cyc.push_back(cyc);
  end

  // Transmitter model: done pulse 10 cycles after each start.
  always @(negedge clk) begin
    if (!uart_reset) begin
      model_cnt  = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          model_done = 1'b1;
          done_cyc.push_back(cyc);
        end
      end
      if (uart_tx_start && tx_en) model_cnt = 10;
    end
  end

  // Requester drivers and spurious done injection.
  always @(negedge clk) begin
    #2;
    if (acc0_p) begin
      acc_id.push_back(0);
      acc_cyc.push_back(acc_at);
      if (q0.size() > 0) q0.delete(0);
    end
    if (acc1_p) begin
      acc_id.push_back(1);
      acc_cyc.push_back(acc_at);
      if (q1.size() > 0) q1.delete(0);
    end
    req0_valid = (q0.size() > 0);
    if (q0.size() > 0) req0_data = q0[0];
    req1_valid = (q1.size() > 0);
    if (q1.size() > 0) req1_data = q1[0];
    spur_done = 1'b0;
    if (spur_idle_pulse) begin
      spur_done       = 1'b1;
      spur_idle_pulse = 1'b0;
    end
    if (spur_start_en && uart_tx_start) spur_done = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic clear_logs();
    start_cyc.delete();
    bytes.delete();
    gid_log.delete();
    done_cyc.delete();
    wd_cyc.delete();
    to_cyc.delete();
    acc_id.delete();
    acc_cyc.delete();
  endtask

  function automatic logic [31:0] word_from_bytes(input int base);
    word_from_bytes = {bytes[base+3], bytes[base+2], bytes[base+1], bytes[base]};
  endfunction

  function automatic logic gid_any();
    gid_any = 1'b0;
    foreach (gid_log[i]) gid_any = gid_any | gid_log[i];
  endfunction

  int ov0;

  initial begin
    // Reset with both requesters already waiting.
    #1 uart_reset = 1'b0;
    q0.push_back(32'h11111111);
    q1.push_back(32'h22222222);
    wait_cyc(3);
    check_eq("rst_ctl", {busy, uart_tx_start, word_done, timeout_err, grant_id, req0_ready, req1_ready}, 7'd0);
    check_eq("rst_data", dataToSend, 8'h00);
    uart_reset = 1'b1;

    // Contention: req0 first, then req1.
    wait_cyc(120);
    check_eq("cont_nacc", acc_id.size(), 2);
    check_eq("cont_first", acc_id[0], 0);
    check_eq("cont_second", acc_id[1], 1);
    check_eq("cont_byte0", bytes[0], 8'h11);
    check_eq("cont_byte4", bytes[4], 8'h22);
    check_eq("cont_gid0", gid_log[0], 1'b0);
    check_eq("cont_gid4", gid_log[4], 1'b1);

    // Third simultaneous request after req1 was served goes to req0.
    clear_logs();
    q0.push_back(32'h33333333);
    q1.push_back(32'h44444444);
    wait_cyc(120);
    check_eq("cont3_first", acc_id[0], 0);
    check_eq("cont3_second", acc_id[1], 1);

    // Single word.
    clear_logs();
    q0.push_back(32'hA1B2C3D4);
    wait_cyc(60);
    check_eq("single_nstart", start_cyc.size(), 4);
    check_eq("single_bytes", word_from_bytes(0), 32'hA1B2C3D4);
    check_eq("single_gid", gid_any(), 1'b0);
    check_eq("single_nwd", wd_cyc.size(), 1);
    check_eq("single_wd_lat", wd_cyc[0] - done_cyc[3], 1);
    check_eq("single_acc_lat", start_cyc[0] - acc_cyc[0], 1);
    check_eq("single_gap", start_cyc[1] - start_cyc[0], 11);

    // Back-to-back words from req1.
    clear_logs();
    ov0 = overlap;
    q1.push_back(32'h55667788);
    q1.push_back(32'h99AABBCC);
    wait_cyc(110);
    check_eq("b2b_nacc", acc_id.size(), 2);
    check_eq("b2b_acc_lat", acc_cyc[1] - done_cyc[3], 2);
    check_eq("b2b_overlap", overlap - ov0, 0);
    check_eq("b2b_bytes0", word_from_bytes(0), 32'h55667788);
    check_eq("b2b_bytes1", word_from_bytes(4), 32'h99AABBCC);
    check_eq("b2b_nwd", wd_cyc.size(), 2);

    // Timeout: transmitter silent.
    clear_logs();
    tx_en = 1'b0;
    q0.push_back(32'hDEADBEEF);
    wait_cyc(70);
    check_eq("to_npulse", to_cyc.size(), 1);
    check_eq("to_lat", to_cyc[0] - start_cyc[0], 50);
    check_eq("to_nwd", wd_cyc.size(), 0);
    check_eq("to_nstart", start_cyc.size(), 1);
    check_eq("to_busy", busy, 1'b0);
    tx_en = 1'b1;
    clear_logs();
    q1.push_back(32'h0BADF00D);
    wait_cyc(60);
    check_eq("to_next_id", acc_id[0], 1);
    check_eq("to_next_bytes", word_from_bytes(0), 32'h0BADF00D);
    check_eq("to_next_nwd", wd_cyc.size(), 1);

    // Reset in the middle of a word.
    clear_logs();
    q1.push_back(32'hCAFEBABE);
    for (int i = 0; i < 60 && start_cyc.size() < 2; i++) @(negedge clk);
    #3;
    check_eq("mid_reached", start_cyc.size() >= 2, 1'b1);
    check_eq("mid_pre_data", dataToSend, 8'hBA);
    uart_reset = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {busy, uart_tx_start, grant_id, req0_ready, req1_ready}, 5'd0);
    check_eq("mid_rst_data", dataToSend, 8'h00);
    @(negedge clk);
    #3 uart_reset = 1'b1;
    clear_logs();
    spur_idle_pulse = 1'b1;
    wait_cyc(5);
    check_eq("mid_stray_nstart", start_cyc.size(), 0);
    check_eq("mid_stray_busy", busy, 1'b0);
    q1.push_back(32'h13579BDF);
    wait_cyc(60);
    check_eq("mid_new_nstart", start_cyc.size(), 4);
    check_eq("mid_new_bytes", word_from_bytes(0), 32'h13579BDF);
    check_eq("mid_new_nwd", wd_cyc.size(), 1);

    // Spurious done in IDLE and in every START.
    clear_logs();
    spur_start_en   = 1'b1;
    spur_idle_pulse = 1'b1;
    wait_cyc(4);
    q0.push_back(32'hA1B2C3D4);
    wait_cyc(60);
    spur_start_en = 1'b0;
    check_eq("spur_nstart", start_cyc.size(), 4);
    check_eq("spur_bytes", word_from_bytes(0), 32'hA1B2C3D4);
    check_eq("spur_wd_lat", wd_cyc[0] - done_cyc[3], 1);
    check_eq("spur_span", start_cyc[3] - start_cyc[0], 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
